// File: rtl/alu_4bit.sv
// alu_4bit: registered 4-bit ALU with sixteen operations and one cycle of latency.
// Optional feature macro: ALU_4BIT_FLAGS_EN. When it is defined, the block adds
// a registered status port flags = {n, v, c, z}. When it is undefined, the port
// and all flag logic are left out, and the result path behaves the same.
// Reset is synchronous and active-low (rst_n). It takes priority over en.

module alu_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sel,
  input  logic       en,
  output logic [3:0] result
`ifdef ALU_4BIT_FLAGS_EN
  ,
  output logic [3:0] flags
`endif
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_NAND = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_XNOR = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_SHL  = 4'b1010,
    OP_SHR  = 4'b1011,
    OP_ROL  = 4'b1100,
    OP_ROR  = 4'b1101,
    OP_INC  = 4'b1110,
    OP_DEC  = 4'b1111
  } op_e;

  op_e        op;
  logic [3:0] result_reg;
  logic [3:0] result_next;

  assign op     = op_e'(sel);
  assign result = result_reg;

  // Combinational operation select; all arithmetic wraps modulo 16.
  always_comb begin
    result_next = 4'b0000;
    case (op)
      OP_ADD:  result_next = a + b;
      OP_SUB:  result_next = a - b;
      OP_MUL:  result_next = a * b;
      OP_AND:  result_next = a & b;
      OP_OR:   result_next = a | b;
      OP_XOR:  result_next = a ^ b;
      OP_NAND: result_next = ~(a & b);
      OP_NOR:  result_next = ~(a | b);
      OP_XNOR: result_next = ~(a ^ b);
      OP_NOT:  result_next = ~a;
      OP_SHL:  result_next = {a[2:0], 1'b0};
      OP_SHR:  result_next = {1'b0, a[3:1]};
      OP_ROL:  result_next = {a[2:0], a[3]};
      OP_ROR:  result_next = {a[0], a[3:1]};
      OP_INC:  result_next = a + 4'd1;
      OP_DEC:  result_next = a - 4'd1;
      default: result_next = 4'b0000;
    endcase
  end

  // Result register: reset wins, otherwise capture only on enabled edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_reg <= 4'b0000;
    end else if (en) begin
      result_reg <= result_next;
    end
  end

`ifdef ALU_4BIT_FLAGS_EN
  logic [4:0] sum_ext;
  logic [4:0] diff_ext;
  logic [7:0] prod_ext;
  logic       c_next;
  logic       v_next;
  logic [3:0] flags_reg;
  logic [3:0] flags_next;

  // Widened copies of the arithmetic results expose carry, borrow and the high product nibble.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign prod_ext = {4'b0000, a} * {4'b0000, b};

  // Carry and signed-overflow per opcode; logic ops clear both.
  always_comb begin
    c_next = 1'b0;
    v_next = 1'b0;
    case (op)
      OP_ADD: begin
        c_next = sum_ext[4];
        v_next = (a[3] == b[3]) && (result_next[3] != a[3]);
      end
      OP_SUB: begin
        c_next = diff_ext[4];
        v_next = (a[3] != b[3]) && (result_next[3] != a[3]);
      end
      OP_MUL: c_next = |prod_ext[7:4];
      OP_SHL, OP_ROL: c_next = a[3];
      OP_SHR, OP_ROR: c_next = a[0];
      OP_INC: begin
        c_next = (a == 4'b1111);
        v_next = (a == 4'b0111);
      end
      OP_DEC: begin
        c_next = (a == 4'b0000);
        v_next = (a == 4'b1000);
      end
      default: begin
        c_next = 1'b0;
        v_next = 1'b0;
      end
    endcase
    flags_next = {result_next[3], v_next, c_next, (result_next == 4'b0000)};
  end

  // Flags register shares the reset and enable behaviour of the result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_reg <= 4'b0000;
    end else if (en) begin
      flags_reg <= flags_next;
    end
  end

  assign flags = flags_reg;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed-vector bench for alu_4bit with hand-computed expectations.
// Flag checks are compiled in only when ALU_4BIT_FLAGS_EN is defined.

module tb_alu_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sel;
  logic       en;
  logic [3:0] result;
`ifdef ALU_4BIT_FLAGS_EN
  logic [3:0] flags;
`endif

  int errors = 0;
  int checks = 0;

  alu_4bit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .en     (en),
    .result (result)
`ifdef ALU_4BIT_FLAGS_EN
    ,
    .flags  (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One transaction: drive the inputs, pass one rising edge, then settle 1 time unit.
  task automatic step(input logic rn, input logic e, input logic [3:0] aa,
                      input logic [3:0] bb, input logic [3:0] ss);
    rst_n = rn;
    en    = e;
    a     = aa;
    b     = bb;
    sel   = ss;
    @(posedge clk);
    #1;
    $display("txn rst_n=%b en=%b a=%b b=%b sel=%b -> result=%b", rn, e, aa, bb, ss, result);
  endtask

  logic [3:0] sweep_exp [16];

  initial begin
    sweep_exp = '{4'b0110, 4'b1110, 4'b1000, 4'b0000, 4'b0110, 4'b0110, 4'b1111, 4'b1001,
                  4'b1001, 4'b1101, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0011, 4'b0001};
    rst_n = 1'b0;
    en    = 1'b0;
    a     = 4'b0000;
    b     = 4'b0000;
    sel   = 4'b0000;

    // Reset while en is high and the operands are non-zero.
    step(1'b0, 1'b1, 4'b0101, 4'b0011, 4'b0000);
    check("reset_result", result, 4'b0000);
`ifdef ALU_4BIT_FLAGS_EN
    check("reset_flags", flags, 4'b0000);
`endif

    // Hold with en low and random inputs.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
      check($sformatf("idle_result_%0d", i), result, 4'b0000);
`ifdef ALU_4BIT_FLAGS_EN
      check($sformatf("idle_flags_%0d", i), flags, 4'b0000);
`endif
    end

    // Opcode sweep with a=0010, b=0100.
    for (int s = 0; s < 16; s++) begin
      step(1'b1, 1'b1, 4'b0010, 4'b0100, 4'(s));
      check($sformatf("sweep_sel_%0d", s), result, sweep_exp[s]);
    end

    // Signed overflow on add.
    step(1'b1, 1'b1, 4'b0111, 4'b0001, 4'b0000);
    check("add_ovf_result", result, 4'b1000);
`ifdef ALU_4BIT_FLAGS_EN
    check("add_ovf_flags", flags, 4'b1100);
`endif

    // Add wrap with carry.
    step(1'b1, 1'b1, 4'b1111, 4'b0001, 4'b0000);
    check("add_wrap_result", result, 4'b0000);
`ifdef ALU_4BIT_FLAGS_EN
    check("add_wrap_flags", flags, 4'b0011);
`endif

    // Sub wrap with borrow.
    step(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0001);
    check("sub_wrap_result", result, 4'b1111);
`ifdef ALU_4BIT_FLAGS_EN
    check("sub_wrap_flags", flags, 4'b1010);
`endif

    // Decrement wrap from 0000 (b ignored).
    step(1'b1, 1'b1, 4'b0000, 4'b1010, 4'b1111);
    check("dec_wrap_result", result, 4'b1111);
`ifdef ALU_4BIT_FLAGS_EN
    check("dec_wrap_flags", flags, 4'b1010);
`endif

    // Increment wrap from 1111.
    step(1'b1, 1'b1, 4'b1111, 4'b0110, 4'b1110);
    check("inc_wrap_result", result, 4'b0000);
`ifdef ALU_4BIT_FLAGS_EN
    check("inc_wrap_flags", flags, 4'b0011);
`endif

    // Rotate left brings a[3] round and into carry.
    step(1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1100);
    check("rotl_result", result, 4'b0001);
`ifdef ALU_4BIT_FLAGS_EN
    check("rotl_flags", flags, 4'b0010);
`endif

    // Multiply 15*15 = 0xE1; high nibble non-zero sets carry.
    step(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0010);
    check("mul_hi_result", result, 4'b0001);
`ifdef ALU_4BIT_FLAGS_EN
    check("mul_hi_flags", flags, 4'b0010);
`endif

    // Shift right logical of 1001: 0100, carry from old a[0].
    step(1'b1, 1'b1, 4'b1001, 4'b0000, 4'b1011);
    check("shr_result", result, 4'b0100);
`ifdef ALU_4BIT_FLAGS_EN
    check("shr_flags", flags, 4'b0010);
`endif

    // Load 0110, then hold for three cycles while the inputs change.
    step(1'b1, 1'b1, 4'b0010, 4'b0100, 4'b0000);
    check("load_0110", result, 4'b0110);
    step(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0001);
    check("hold_0", result, 4'b0110);
    step(1'b1, 1'b0, 4'b1010, 4'b0101, 4'b0111);
    check("hold_1", result, 4'b0110);
    step(1'b1, 1'b0, 4'b0001, 4'b1110, 4'b1001);
    check("hold_2", result, 4'b0110);

    // Reset beats en.
    step(1'b0, 1'b1, 4'b0111, 4'b0111, 4'b0000);
    check("reset_over_en", result, 4'b0000);
`ifdef ALU_4BIT_FLAGS_EN
    check("reset_over_en_flags", flags, 4'b0000);
`endif

    // The first enabled edge after reset gives a normal result.
    step(1'b1, 1'b1, 4'b0011, 4'b0100, 4'b0000);
    check("post_reset_add", result, 4'b0111);

    // Changes to the inputs between edges must not reach the output.
    a   = 4'b1001;
    b   = 4'b1001;
    sel = 4'b0101;
    #3;
    check("between_edges", result, 4'b0111);
    step(1'b1, 1'b1, 4'b1001, 4'b1001, 4'b0101);
    check("xor_self_zero", result, 4'b0000);
`ifdef ALU_4BIT_FLAGS_EN
    check("xor_self_zero_flags", flags, 4'b0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Ports: clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 Ports: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Ports: a  input  4  operand A, unsigned or two's complement per opcode.
REQ-005 Ports: b  input  4  operand B.
REQ-006 Ports: sel  input  4  opcode; see Function.
REQ-007 Ports: en  input  1  operation enable; high = capture a new result this edge.
REQ-008 Ports: result  output  4  registered operation result.
REQ-009 Ports: flags  output  4  registered status {n, v, c, z}, bit3..bit0; present only when ALU_4BIT_FLAGS_EN is defined.

Function
REQ-010 On a rising clk edge with rst_n=1 and en=1, result SHALL load op(sel, a, b); latency is exactly 1 cycle.
REQ-011 With rst_n=1 and en=0, result and flags SHALL hold their previous values.
REQ-012 Opcodes: 0000 a+b; 0001 a-b; 0010 low nibble of a*b; 0011 a AND b; 0100 a OR b; 0101 a XOR b; 0110 NAND; 0111 NOR.
REQ-013 Opcodes: 1000 XNOR; 1001 NOT a; 1010 a<<1 (zero fill); 1011 a>>1 logical; 1100 rotate a left 1; 1101 rotate a right 1; 1110 a+1; 1111 a-1.
REQ-014 All arithmetic SHALL be 4-bit modulo 16; b is ignored for opcodes 1001-1111.
REQ-015 Wrap-around: 1111+0001 -> 0000; 0000-0001 -> 1111; a=1111 inc -> 0000; a=0000 dec -> 1111.
REQ-016 c: add/inc carry-out; sub/dec borrow (1 when unsigned a < subtrahend); mul 1 when bits[7:4] of the 8-bit product are nonzero; shl/rotl old a[3]; shr/rotr old a[0]; logic ops 0.
REQ-017 v: signed overflow for add, sub, inc, dec; 0 for all other opcodes.
REQ-018 z SHALL be 1 when the new result is 0000; n SHALL equal new result[3].
REQ-019 Flags SHALL update on the same edge and under the same en condition as result.
REQ-020 Inputs SHALL be sampled only at the clock edge; input changes between edges SHALL not affect outputs.

Reset
REQ-021 rst_n=0 at a rising edge SHALL force result=0000 and flags=0000, regardless of en or sel.
REQ-022 Reset SHALL take priority over en; reset mid-operation SHALL discard the pending computation.
REQ-023 The first enabled edge after rst_n returns high SHALL produce a normal result.

Configuration
REQ-024 Macro ALU_4BIT_FLAGS_EN defined: flags port and its registers SHALL exist per REQ-016..REQ-019.
REQ-025 Macro ALU_4BIT_FLAGS_EN undefined: flags port and all flag logic SHALL be absent; result behaviour SHALL be unchanged.

Verification
REQ-026 Reset then en=0 for 5 cycles with random a/b/sel -> result=0000, flags=0000 throughout.
REQ-027 a=0010, b=0100, en=1, sweep sel 0000..1111 one per cycle -> results 0110,1110,1000,0000,0110,0110,1111,1001,1001,1101,0100,0001,0100,0001,0011,0001, each one cycle after sel applied.
REQ-028 a=0111, b=0001, sel=0000 -> result=1000, flags n=1 v=1 c=0 z=0; a=1111, b=0001, sel=0000 -> result=0000, c=1 z=1 v=0.
REQ-029 a=0000, sel=1111 -> result=1111, c=1 n=1; a=1000, sel=1100 -> result=0001, c=1.
REQ-030 Load result 0110, drop en, change a/b/sel for 3 cycles -> result stays 0110; assert rst_n=0 with en=1 -> next edge result=0000.
REQ-031 Build with and without ALU_4BIT_FLAGS_EN -> identical result sequence for REQ-027 stimulus.
